// File: rtl/cache_miss_sequencer_pkg.sv
// Shared definitions for the cache-miss sequencer and the dma-facing bus stages:
// sequencer state encoding, line geometry defaults and the line-alignment helper.
package cache_miss_sequencer_pkg;

  // Sequencer phases: optional write-back, then refill, then a one-cycle response.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_REQ   = 3'd1,
    WB_DRAIN = 3'd2,
    RF_REQ   = 3'd3,
    RF_DRAIN = 3'd4,
    RESP     = 3'd5
  } seq_state_e;

  // A cache line is LINE_BEATS beats of 32 bits; the dma is told LINE_BEATS-1.
  localparam int DEFAULT_LINE_BEATS = 8;
  localparam int DEFAULT_BURST_LEN  = DEFAULT_LINE_BEATS - 1;
  localparam int BEAT_BYTES_LOG2    = 2;

  // Number of low address bits that select a byte inside one line.
  function automatic int line_offset_bits(input int line_beats);
    return $clog2(line_beats) + BEAT_BYTES_LOG2;
  endfunction

endpackage

// File: rtl/cache_miss_sequencer_if.sv
// Bundle of the cache request/response handshake and both dma request channels.
// The slave modport is the sequencer's view; master is the cache/dma side.
interface cache_miss_sequencer_if
  import cache_miss_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8
);

  // Cache miss request and completion
  logic                       miss_valid;
  logic                       miss_ready;
  logic [ADDR_WIDTH-1:0]      miss_addr;
  logic                       miss_victim_dirty;
  logic [ADDR_WIDTH-1:0]      miss_victim_addr;
  logic                       resp_valid;
  logic                       resp_err;

  // Dma write-back channel (level request, level done)
  logic                       dma_write_back_happen;
  logic [ADDR_WIDTH-1:0]      dma_write_back_addr;
  logic [WRITE_BURST_LEN-1:0] dma_write_back_burst_len;
  logic                       dma_write_back_done;

  // Dma refill (page-fault) channel
  logic                       dma_page_fault_happen;
  logic [ADDR_WIDTH-1:0]      dma_page_fault_addr;
  logic [READ_BURST_LEN-1:0]  dma_page_fault_burst_len;
  logic                       dma_page_fault_done;

  modport slave (
    input  miss_valid, miss_addr, miss_victim_dirty, miss_victim_addr,
    input  dma_write_back_done, dma_page_fault_done,
    output miss_ready, resp_valid, resp_err,
    output dma_write_back_happen, dma_write_back_addr, dma_write_back_burst_len,
    output dma_page_fault_happen, dma_page_fault_addr, dma_page_fault_burst_len
  );

  modport master (
    output miss_valid, miss_addr, miss_victim_dirty, miss_victim_addr,
    output dma_write_back_done, dma_page_fault_done,
    input  miss_ready, resp_valid, resp_err,
    input  dma_write_back_happen, dma_write_back_addr, dma_write_back_burst_len,
    input  dma_page_fault_happen, dma_page_fault_addr, dma_page_fault_burst_len
  );

endinterface

// File: rtl/cache_miss_sequencer_watchdog.sv
// Phase watchdog: clear restarts the count, enable advances it, and timeout is
// raised while enabled once TIMEOUT_CYCLES-1 is reached. The count saturates.
module cache_miss_sequencer_watchdog
  import cache_miss_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_reg;

  // Count cycles spent in the current phase; clear wins over enable, never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != SAT)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign timeout = enable && (count_reg >= LIMIT);

endmodule

// File: rtl/cache_miss_sequencer.sv
// Cache-miss sequencer: accepts one line miss, optionally writes the dirty victim
// back through the dma, refills the line, then reports completion or timeout.
module cache_miss_sequencer
  import cache_miss_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8,
  parameter int LINE_BEATS      = DEFAULT_LINE_BEATS,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic                   cpu_clk,
  input logic                   cpu_rst,
  cache_miss_sequencer_if.slave bus
);

  // Clears the byte-within-line bits so the dma always sees line-aligned bursts.
  localparam int OFFSET_BITS = line_offset_bits(LINE_BEATS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  seq_state_e            state_reg;
  seq_state_e            state_next;
  logic [ADDR_WIDTH-1:0] miss_addr_reg;
  logic [ADDR_WIDTH-1:0] victim_addr_reg;
  logic                  err_reg;
  logic                  err_next;

  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_timeout;

  // The watchdog runs only while a dma phase is outstanding and restarts on every
  // state change, so each REQ and DRAIN phase gets its own full budget.
  assign wd_enable = (state_reg == WB_REQ) || (state_reg == WB_DRAIN) ||
                     (state_reg == RF_REQ) || (state_reg == RF_DRAIN);
  assign wd_clear  = (state_next != state_reg);

  cache_miss_sequencer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .timeout (wd_timeout)
  );

  // State register; reset aborts any request in flight without a response.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request capture and error flag; addresses only change at the accept edge.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      miss_addr_reg   <= '0;
      victim_addr_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      err_reg <= err_next;
      if ((state_reg == IDLE) && bus.miss_valid) begin
        miss_addr_reg   <= bus.miss_addr & LINE_MASK;
        victim_addr_reg <= bus.miss_victim_addr & LINE_MASK;
      end
    end
  end

  // Next-state: done completes a REQ phase even if the watchdog fires in the same
  // cycle; a timeout in any phase skips straight to an error response.
  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.miss_valid) begin
          err_next   = 1'b0;
          state_next = bus.miss_victim_dirty ? WB_REQ : RF_REQ;
        end
      end
      WB_REQ: begin
        if (bus.dma_write_back_done) begin
          state_next = WB_DRAIN;
        end else if (wd_timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      WB_DRAIN: begin
        if (!bus.dma_write_back_done) begin
          state_next = RF_REQ;
        end else if (wd_timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RF_REQ: begin
        if (bus.dma_page_fault_done) begin
          state_next = RF_DRAIN;
        end else if (wd_timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RF_DRAIN: begin
        if (!bus.dma_page_fault_done) begin
          state_next = RESP;
        end else if (wd_timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs: each dma channel is driven only in its own REQ state, so the
  // two happen lines can never be high together and are quiet outside a request.
  always_comb begin
    bus.miss_ready               = 1'b0;
    bus.resp_valid               = 1'b0;
    bus.resp_err                 = 1'b0;
    bus.dma_write_back_happen    = 1'b0;
    bus.dma_write_back_addr      = '0;
    bus.dma_write_back_burst_len = '0;
    bus.dma_page_fault_happen    = 1'b0;
    bus.dma_page_fault_addr      = '0;
    bus.dma_page_fault_burst_len = '0;
    unique case (state_reg)
      IDLE: begin
        bus.miss_ready = 1'b1;
      end
      WB_REQ: begin
        bus.dma_write_back_happen    = 1'b1;
        bus.dma_write_back_addr      = victim_addr_reg;
        bus.dma_write_back_burst_len = WRITE_BURST_LEN'(LINE_BEATS - 1);
      end
      RF_REQ: begin
        bus.dma_page_fault_happen    = 1'b1;
        bus.dma_page_fault_addr      = miss_addr_reg;
        bus.dma_page_fault_burst_len = READ_BURST_LEN'(LINE_BEATS - 1);
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_reg;
      end
      default: begin
      end
    endcase
  end

  // A done already high when a request phase starts is left over from an earlier
  // transfer; the FSM still treats it as completion, but it is flagged here.
  wb_done_high_on_entry: assert property (
    @(posedge cpu_clk) disable iff (cpu_rst)
    $rose(state_reg == WB_REQ) |-> !bus.dma_write_back_done
  );

  pf_done_high_on_entry: assert property (
    @(posedge cpu_clk) disable iff (cpu_rst)
    $rose(state_reg == RF_REQ) |-> !bus.dma_page_fault_done
  );

  happen_exclusive: assert property (
    @(posedge cpu_clk) disable iff (cpu_rst)
    !(bus.dma_write_back_happen && bus.dma_page_fault_happen)
  );

endmodule
